// File: rtl/ipsl_expd_apb_pkg.sv
// Shared widths, FSM encoding and defaults for the expansion-space APB fan-out.
package ipsl_expd_apb_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int STRB_W    = 4;
    localparam int ERR_CNT_W = 16;

    localparam logic [DATA_W-1:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_REL    = 2'd3
    } apb_state_t;

endpackage

// File: rtl/ipsl_expd_apb_dec.sv
// Priority address decoder: addr[15:12] against a packed nibble table, lowest index wins.
module ipsl_expd_apb_dec #(
    parameter int                   SLV_NUM    = 4,
    parameter logic [4*SLV_NUM-1:0] SLV_NIBBLE = {4'h4, 4'h3, 4'h1, 4'h0}
) (
    input  logic [3:0]         addr_nibble,
    output logic [SLV_NUM-1:0] hit_onehot,
    output logic               hit
);

    logic [SLV_NUM-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < SLV_NUM; gi++) begin : g_slv
            assign match[gi] = (addr_nibble == SLV_NIBBLE[4*gi +: 4]);
            // Duplicate table entries resolve to the lowest matching index.
            if (gi == 0) begin : g_first
                assign hit_onehot[gi] = match[gi];
            end else begin : g_rest
                assign hit_onehot[gi] = match[gi] & ~(|match[gi-1:0]);
            end
        end
    endgenerate

    assign hit = |match;

endmodule

// File: rtl/ipsl_expd_apb_mux_n.sv
// Registered APB fan-out with per-access timeout, error response and saturating error counter.
module ipsl_expd_apb_mux_n
    import ipsl_expd_apb_pkg::*;
#(
    parameter int                   SLV_NUM     = 4,
    parameter logic [4*SLV_NUM-1:0] SLV_NIBBLE  = {4'h4, 4'h3, 4'h1, 4'h0},
    parameter int                   TIMEOUT_CYC = 256,
    parameter logic [DATA_W-1:0]    ERR_RDATA   = DEF_ERR_RDATA,
    // Saturation point of the error counter; lowered only to make saturation reachable in short runs.
    parameter logic [ERR_CNT_W-1:0] ERR_CNT_SAT = '1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_p_sel,
    input  logic                      i_p_ce,
    input  logic                      i_p_we,
    input  logic [STRB_W-1:0]         i_p_strb,
    input  logic [ADDR_W-1:0]         i_p_addr,
    input  logic [DATA_W-1:0]         i_p_wdata,
    output logic                      o_p_rdy,
    output logic [DATA_W-1:0]         o_p_rdata,
    output logic                      o_p_err,
    output logic [SLV_NUM-1:0]        o_slv_p_sel,
    output logic                      o_slv_p_ce,
    output logic                      o_slv_p_we,
    output logic [STRB_W-1:0]         o_slv_p_strb,
    output logic [ADDR_W-1:0]         o_slv_p_addr,
    output logic [DATA_W-1:0]         o_slv_p_wdata,
    input  logic [SLV_NUM-1:0]        i_slv_p_rdy,
    input  logic [DATA_W*SLV_NUM-1:0] i_slv_p_rdata,
    output logic [ERR_CNT_W-1:0]      o_err_cnt
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    apb_state_t            state_reg, state_next;
    logic [SLV_NUM-1:0]    sel_reg, sel_next;
    logic [ADDR_W-1:0]     addr_reg, addr_next;
    logic [DATA_W-1:0]     wdata_reg, wdata_next;
    logic [STRB_W-1:0]     strb_reg, strb_next;
    logic                  we_reg, we_next;
    logic [DATA_W-1:0]     rdata_reg, rdata_next;
    logic                  err_reg, err_next;
    logic [15:0]           tmo_reg, tmo_next;
    logic [ERR_CNT_W-1:0]  err_cnt_reg, err_cnt_next;

    logic [SLV_NUM-1:0]    dec_onehot;
    logic                  dec_hit;
    logic [DATA_W-1:0]     slv_rdata_sel;
    logic                  slv_rdy_hit;

    ipsl_expd_apb_dec #(
        .SLV_NUM    (SLV_NUM),
        .SLV_NIBBLE (SLV_NIBBLE)
    ) u_dec (
        .addr_nibble (i_p_addr[ADDR_W-1 -: 4]),
        .hit_onehot  (dec_onehot),
        .hit         (dec_hit)
    );

    // Only the selected completer's ready and data are ever looked at.
    assign slv_rdy_hit = |(i_slv_p_rdy & sel_reg);

    always_comb begin
        slv_rdata_sel = '0;
        for (int i = 0; i < SLV_NUM; i++) begin
            if (sel_reg[i]) begin
                slv_rdata_sel = slv_rdata_sel | i_slv_p_rdata[DATA_W*i +: DATA_W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            sel_reg     <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            strb_reg    <= '0;
            we_reg      <= 1'b0;
            rdata_reg   <= '0;
            err_reg     <= 1'b0;
            tmo_reg     <= '0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            strb_reg    <= strb_next;
            we_reg      <= we_next;
            rdata_reg   <= rdata_next;
            err_reg     <= err_next;
            tmo_reg     <= tmo_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        strb_next    = strb_reg;
        we_next      = we_reg;
        rdata_next   = rdata_reg;
        err_next     = err_reg;
        tmo_next     = tmo_reg;
        err_cnt_next = err_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (i_p_sel && i_p_ce) begin
                    addr_next  = i_p_addr;
                    wdata_next = i_p_wdata;
                    strb_next  = i_p_strb;
                    we_next    = i_p_we;
                    sel_next   = dec_onehot;
                    tmo_next   = '0;
                    if (dec_hit) begin
                        state_next = ST_ACCESS;
                    end else begin
                        err_next   = 1'b1;
                        rdata_next = ERR_RDATA;
                        state_next = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                // Ready is checked before the timeout so a last-cycle ready still succeeds.
                if (slv_rdy_hit) begin
                    rdata_next = slv_rdata_sel;
                    err_next   = 1'b0;
                    state_next = ST_RESP;
                end else if (tmo_reg == TMO_LAST) begin
                    rdata_next = ERR_RDATA;
                    err_next   = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    tmo_next = tmo_reg + 16'd1;
                end
            end
            ST_RESP: begin
                if (err_reg && (err_cnt_reg != ERR_CNT_SAT)) begin
                    err_cnt_next = err_cnt_reg + 1'b1;
                end
                state_next = ST_REL;
            end
            ST_REL: begin
                if (!i_p_ce) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign o_slv_p_sel   = (state_reg == ST_ACCESS) ? sel_reg : '0;
    assign o_slv_p_ce    = (state_reg == ST_ACCESS);
    assign o_slv_p_we    = we_reg;
    assign o_slv_p_strb  = strb_reg;
    assign o_slv_p_addr  = addr_reg;
    assign o_slv_p_wdata = wdata_reg;

    assign o_p_rdy   = (state_reg == ST_RESP);
    assign o_p_rdata = (state_reg == ST_RESP) ? rdata_reg : '0;
    assign o_p_err   = (state_reg == ST_RESP) ? err_reg : 1'b0;
    assign o_err_cnt = err_cnt_reg;

endmodule

// File: doc/ipsl_expd_apb_mux_n.md
Name: ipsl_expd_apb_mux_n

Overview:
Parametrised, registered APB fan-out for the expansion register space. One APB requester is decoded on addr[15:12] to one of SLV_NUM completers, with the downstream bus shared. A transaction FSM adds per-access timeout, an error response for unmapped or hung accesses, and a saturating error counter. Everything runs in one clock domain; any clock-domain crossing happens upstream of this block.

Parameters:
SLV_NUM, 4, number of downstream completers (1..8)
SLV_NIBBLE, {4'h4,4'h3,4'h1,4'h0}, packed 4 bits per slave; slave i decodes addr[15:12]==SLV_NIBBLE[4*i+:4]
TIMEOUT_CYC, 256, ACCESS cycles before abort (2..65535)
ERR_RDATA, 32'hDEAD_BEEF, read data returned on error

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_p_sel  in  1  requester select
i_p_ce  in  1  requester enable
i_p_we  in  1  1=write
i_p_strb  in  4  byte strobes
i_p_addr  in  16  address
i_p_wdata  in  32  write data
o_p_rdy  out  1  one-cycle completion pulse
o_p_rdata  out  32  read data, valid with o_p_rdy
o_p_err  out  1  error, valid with o_p_rdy
o_slv_p_sel  out  SLV_NUM  one-hot completer select
o_slv_p_ce  out  1  shared enable
o_slv_p_we  out  1  shared write flag
o_slv_p_strb  out  4  shared strobes
o_slv_p_addr  out  16  shared address
o_slv_p_wdata  out  32  shared write data
i_slv_p_rdy  in  SLV_NUM  per-completer ready
i_slv_p_rdata  in  32*SLV_NUM  per-completer read data, slave i at [32*i+:32]
o_err_cnt  out  16  saturating count of error completions

Behaviour:
- Reset: i_clk and i_rst are the single clock and reset; the reset is synchronous and active-high. While i_rst is high, all outputs are 0, the FSM goes to IDLE and the counters clear. Reset mid-transaction drops o_slv_p_sel/ce on the next edge. No o_p_rdy is issued for the aborted access.
- FSM states: IDLE, ACCESS, RESP, REL.
- IDLE:
  - A request is accepted when i_p_sel & i_p_ce are both high. On acceptance, register addr, wdata, strb and we.
  - Decode the one-hot hit. On duplicate SLV_NIBBLE entries, the lowest index wins.
  - On a hit, go to ACCESS. On a miss, go to RESP with err=1 and rdata=ERR_RDATA. No downstream select is driven on a miss.
- ACCESS:
  - o_slv_p_sel[idx]=1 and o_slv_p_ce=1. The shared address, data, strobe and we outputs come from the registered copies and are stable for the whole access.
  - If i_slv_p_rdy[idx]=1, capture i_slv_p_rdata[idx], set err=0 and go to RESP.
  - Ready from non-selected slaves is ignored.
  - The timeout counter starts at 0 on entry and increments each cycle. On reaching TIMEOUT_CYC-1 without ready, go to RESP with err=1 and rdata=ERR_RDATA.
  - If ready and timeout occur in the same cycle, ready wins (err=0).
- RESP:
  - o_p_rdy=1 for exactly one cycle, with o_p_rdata and o_p_err.
  - o_slv_p_sel/ce are 0 in this state.
  - If err=1, o_err_cnt increments, saturating at 16'hFFFF.
  - Next state is REL.
- REL: wait until i_p_ce=0, then go to IDLE. This prevents a held request from being accepted twice.
- Outside RESP: o_p_rdata=0 and o_p_err=0.
- Latency:
  - Hit with ready on the first ACCESS cycle: acceptance at edge T, ACCESS during T..T+1, o_p_rdy during T+1..T+2. That is 2 cycles from acceptance, minimum.
  - Miss: o_p_rdy 1 cycle after acceptance.
  - Timeout: o_p_rdy TIMEOUT_CYC+1 cycles after acceptance.
- Requester inputs are ignored outside IDLE and REL.
- Writes and reads use the same path. For writes, o_p_rdata carries the captured slave rdata (don't-care upstream).

Decomposition:
- Package ipsl_expd_apb_pkg: FSM state encoding, ADDR_W=16, DATA_W=32, STRB_W=4, ERR_CNT_W=16, default ERR_RDATA.
- One sub-module ipsl_expd_apb_dec: combinational priority decoder, addr nibble plus SLV_NIBBLE to one-hot hit vector and hit flag. Parametrised by SLV_NUM.
- FSM, registers, rdata mux and counters stay in the top module.

Test Plan:
- Read hit: addr 16'h3010, slave 2 (nibble 3) ready on first ACCESS cycle with rdata 32'h1234_5678 -> o_slv_p_sel=4'b0100; o_p_rdy exactly 2 cycles after acceptance; o_p_rdata=32'h1234_5678; o_p_err=0.
- Write hit with wait states: addr 16'h4004, wdata 32'hA5A5_0F0F, strb 4'b0011, slave 3 ready after 5 cycles -> shared address/data/strb stable for all 5 ACCESS cycles; one o_p_rdy pulse; err=0; o_err_cnt unchanged.
- Unmapped: addr 16'h8000 -> no o_slv_p_sel bit ever set; o_p_rdy 1 cycle after acceptance; rdata=32'hDEAD_BEEF; err=1; o_err_cnt=1.
- Timeout: TIMEOUT_CYC=8, slave 0 never ready -> sel held exactly 8 cycles, then dropped; err=1 pulse; next access to slave 1 completes normally. Repeat with ready on the 8th cycle -> err=0.
- Held request / REL: requester keeps i_p_ce=1 for 10 cycles after o_p_rdy -> only one downstream access occurs; after ce drops and is reasserted, a second access occurs.
- Reset mid-ACCESS plus saturation: assert i_rst during ACCESS -> all outputs 0 on the next edge, no o_p_rdy. Force o_err_cnt to 16'hFFFF via repeated misses (or a small-width sim override) -> stays at 16'hFFFF.
